// File: rtl/row_clear_engine.sv
// -----------------------------------------------------------------------------
// row_clear_engine
// Post-lock board clean-up for the 20x10 Tetris playfield. On a start pulse
// the locked board is snapshotted. Every completely filled row is removed and
// the rows above it collapse downward. The compacted board is returned together
// with the number of rows removed by this operation and a saturating running
// total of rows removed since reset.
//
// Ports
//   clk          : system clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle request; screen is sampled in the same cycle
//   screen       : locked board, row 0 is the bottom row, 1 = occupied
//   outputScreen : compacted board (registered, held between done pulses)
//   busy         : high while the row scan is in progress
//   done         : one-cycle pulse when outputScreen/linesCleared update
//   linesCleared : rows removed by the last operation (saturates at 7)
//   totalLines   : running total of removed rows, saturates at 1023
// -----------------------------------------------------------------------------
module row_clear_engine (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [19:0][9:0] screen,
    output logic [19:0][9:0] outputScreen,
    output logic             busy,
    output logic             done,
    output logic [2:0]       linesCleared,
    output logic [9:0]       totalLines
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [19:0][9:0] board_r;
    logic [4:0]       row_r;
    logic [2:0]       cnt_r;

    logic [9:0]       cur_row_s;
    logic             row_full_s;
    logic [19:0][9:0] shifted_s;
    logic [10:0]      total_sum_s;
    logic [9:0]       total_next_s;

    // A row is full when all ten cells are occupied.
    function automatic logic row_is_full(input logic [9:0] row);
        return &row;
    endfunction

    // Row-removal datapath: drop every row at or above row_r by one place,
    // feed an empty row in at the top, and form the saturating total.
    always_comb begin
        cur_row_s  = board_r[row_r];
        row_full_s = row_is_full(cur_row_s);
        for (int k = 0; k < 19; k++) begin
            if (5'(k) < row_r) begin
                shifted_s[k] = board_r[k];
            end else begin
                shifted_s[k] = board_r[k + 1];
            end
        end
        // row_r never exceeds 19, so the top row is always refilled empty.
        shifted_s[19] = 10'd0;
        total_sum_s   = {1'b0, totalLines} + {8'd0, cnt_r};
        if (total_sum_s > 11'd1023) begin
            total_next_s = 10'h3FF;
        end else begin
            total_next_s = total_sum_s[9:0];
        end
    end

    // Control FSM with registered outputs; also owns the working board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            board_r      <= '0;
            row_r        <= 5'd0;
            cnt_r        <= 3'd0;
            outputScreen <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            linesCleared <= 3'd0;
            totalLines   <= 10'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    // A start landing in the done-pulse cycle is dropped so a
                    // request is only taken once the result has been presented.
                    if (start && !done) begin
                        board_r <= screen;
                        row_r   <= 5'd0;
                        cnt_r   <= 3'd0;
                        busy    <= 1'b1;
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full_s) begin
                        // row_r is kept so the row that dropped in is re-checked.
                        board_r <= shifted_s;
                        if (cnt_r != 3'd7) begin
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end else if (row_r == 5'd19) begin
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        row_r <= row_r + 5'd1;
                    end
                end
                DONE: begin
                    outputScreen <= board_r;
                    linesCleared <= cnt_r;
                    totalLines   <= total_next_s;
                    done         <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_clear_engine.sv
module tb_row_clear_engine;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [19:0][9:0] screen;
    logic [19:0][9:0] outputScreen;
    logic             busy;
    logic             done;
    logic [2:0]       linesCleared;
    logic [9:0]       totalLines;

    int tests = 0;
    int fails = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    row_clear_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .screen       (screen),
        .outputScreen (outputScreen),
        .busy         (busy),
        .done         (done),
        .linesCleared (linesCleared),
        .totalLines   (totalLines)
    );

    // Reference: keep non-full rows in bottom-up order and pad the top with empty rows.
    function automatic void model(input logic [19:0][9:0] b, output logic [19:0][9:0] o,
                                  output int k);
        int j;
        o = '0;
        k = 0;
        j = 0;
        for (int i = 0; i < 20; i++) begin
            if (b[i] == 10'h3FF) k++;
            else begin
                o[j] = b[i];
                j++;
            end
        end
    endfunction

    function automatic int sat_total(input int t, input int c);
        return (t + c > 1023) ? 1023 : t + c;
    endfunction

    function automatic logic [19:0][9:0] rand_board(input int full_pct);
        logic [19:0][9:0] b;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(99) < full_pct) b[i] = 10'h3FF;
            else b[i] = 10'($urandom) & 10'h1FF;
        end
        return b;
    endfunction

    // Stimulus only: start one operation, scramble screen afterwards, wait for done.
    task automatic run_op(input logic [19:0][9:0] b, output int lat, output logic busy1,
                          output logic done_next);
        @(negedge clk);
        screen = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) screen[i] = 10'($urandom);
        busy1 = busy;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        done_next = 1'b1;
        if (done) begin
            @(posedge clk);
            #1;
            done_next = done;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        screen = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (outputScreen !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            linesCleared !== 3'd0 || totalLines !== 10'd0) begin
            fails++;
            $display("FAIL reset: got busy=%b done=%b lines=%0d total=%0d scr=%h, need all 0",
                     busy, done, linesCleared, totalLines, outputScreen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_total = 0;
    endtask

    task automatic test_directed();
        logic [19:0][9:0] b [5];
        logic [19:0][9:0] eo;
        int k, lat, el;
        logic b1, dn;
        string nm [5] = '{"empty", "single", "tetris", "nonadj", "rows5_14"};
        for (int t = 0; t < 5; t++) b[t] = '0;
        b[1][0] = 10'h3FF; b[1][1] = 10'h001;
        for (int i = 0; i < 4; i++) b[2][i] = 10'h3FF;
        b[2][4] = 10'h200; b[2][5] = 10'h201;
        b[3][2] = 10'h3FF; b[3][5] = 10'h3FF; b[3][19] = 10'h3FF;
        b[3][3] = 10'h0F0; b[3][6] = 10'h00F;
        for (int i = 0; i < 5; i++) b[4][i] = 10'(i + 1);
        for (int i = 5; i < 15; i++) b[4][i] = 10'h3FF;
        for (int t = 0; t < 5; t++) begin
            model(b[t], eo, k);
            el = (k > 7) ? 7 : k;
            exp_total = sat_total(exp_total, el);
            run_op(b[t], lat, b1, dn);
            tests++;
            if (b1 !== 1'b1) begin
                fails++; $display("FAIL %s busy: got %b need 1", nm[t], b1);
            end
            tests++;
            if (lat != 21 + k) begin
                fails++; $display("FAIL %s latency: got %0d need %0d", nm[t], lat, 21 + k);
            end
            tests++;
            if (outputScreen !== eo) begin
                fails++; $display("FAIL %s screen: got %h need %h", nm[t], outputScreen, eo);
            end
            tests++;
            if (linesCleared !== 3'(el)) begin
                fails++; $display("FAIL %s lines: got %0d need %0d", nm[t], linesCleared, el);
            end
            tests++;
            if (totalLines !== 10'(exp_total)) begin
                fails++; $display("FAIL %s total: got %0d need %0d", nm[t], totalLines, exp_total);
            end
            tests++;
            if (dn !== 1'b0) begin
                fails++; $display("FAIL %s done_width: got %b need 0", nm[t], dn);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0][9:0] b, eo;
        int k, lat, el;
        logic b1, dn;
        for (int n = 0; n < 30; n++) begin
            b = rand_board(30);
            model(b, eo, k);
            el = (k > 7) ? 7 : k;
            exp_total = sat_total(exp_total, el);
            run_op(b, lat, b1, dn);
            tests++;
            if (lat != 21 + k || outputScreen !== eo || linesCleared !== 3'(el) ||
                totalLines !== 10'(exp_total) || dn !== 1'b0) begin
                fails++;
                $display("FAIL random%0d: got lat=%0d lines=%0d total=%0d, need lat=%0d lines=%0d total=%0d",
                         n, lat, linesCleared, totalLines, 21 + k, el, exp_total);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [19:0][9:0] b1, b2, eo;
        int k, lat, el;
        b1 = rand_board(25);
        b2 = '1;
        model(b1, eo, k);
        el = (k > 7) ? 7 : k;
        exp_total = sat_total(exp_total, el);
        @(negedge clk);
        screen = b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        screen = b2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (lat != 21 + k || outputScreen !== eo || linesCleared !== 3'(el)) begin
            fails++;
            $display("FAIL start_busy: got lat=%0d lines=%0d, need lat=%0d lines=%0d",
                     lat, linesCleared, 21 + k, el);
        end
        // start held during the done cycle must be dropped
        start = 1'b1; screen = b2;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL start_on_done: got busy=%b need 0", busy);
        end
        repeat (3) @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || totalLines !== 10'(exp_total)) begin
            fails++;
            $display("FAIL start_on_done_idle: got done=%b busy=%b total=%0d need 0 0 %0d",
                     done, busy, totalLines, exp_total);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0][9:0] b, eo;
        int k, lat;
        logic b1, dn, seen;
        b = '0;
        for (int i = 0; i < 4; i++) b[i] = 10'h3FF;
        @(negedge clk);
        screen = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (outputScreen !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            linesCleared !== 3'd0 || totalLines !== 10'd0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b lines=%0d total=%0d, need all 0",
                     busy, done, linesCleared, totalLines);
        end
        exp_total = 0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL reset_mid_nodone: got activity=%b need 0", seen);
        end
        b = rand_board(30);
        model(b, eo, k);
        exp_total = sat_total(exp_total, (k > 7) ? 7 : k);
        run_op(b, lat, b1, dn);
        tests++;
        if (lat != 21 + k || outputScreen !== eo || totalLines !== 10'(exp_total)) begin
            fails++;
            $display("FAIL reset_recover: got lat=%0d total=%0d need lat=%0d total=%0d",
                     lat, totalLines, 21 + k, exp_total);
        end
    endtask

    task automatic test_saturation();
        logic [19:0][9:0] b, eo;
        int k, lat, n, bad;
        logic b1, dn;
        bad = 0;
        for (int it = 0; it < 300 && exp_total < 1023; it++) begin
            if (exp_total <= 1018) n = 4;
            else if (exp_total < 1022) n = 1022 - exp_total;
            else n = 4;
            b = rand_board(0);
            for (int i = 0; i < n; i++) b[i] = 10'h3FF;
            model(b, eo, k);
            exp_total = sat_total(exp_total, k);
            run_op(b, lat, b1, dn);
            if (totalLines !== 10'(exp_total) || lat != 21 + k) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL sat_ramp: got %0d bad ops need 0", bad);
        end
        tests++;
        if (totalLines !== 10'd1023) begin
            fails++; $display("FAIL sat_total: got %0d need 1023", totalLines);
        end
        b = '0;
        for (int i = 0; i < 4; i++) b[i] = 10'h3FF;
        run_op(b, lat, b1, dn);
        tests++;
        if (totalLines !== 10'd1023 || linesCleared !== 3'd4) begin
            fails++;
            $display("FAIL sat_hold: got total=%0d lines=%0d need 1023 4", totalLines, linesCleared);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
